axis_hex_formatter: RTL and testbench
=====================================

AXIS_HEX_FORMATTER -- requirements
Module: axis_hex_formatter

Interface
REQ-001 The block SHALL have parameter BYTES_PER_LINE, default 16: number of input bytes per output text line (range 1..255).
REQ-002 The block SHALL have parameter UPPERCASE, default 1: 1 selects 'A'-'F' for hex digits; 0 selects 'a'-'f'.
REQ-003 The block SHALL have port clk125 input 1: system clock, all logic on its rising edge.
REQ-004 The block SHALL have port reset input 1: synchronous, active-high reset.
REQ-005 The block SHALL have port s_axis_tdata input 8: raw byte in.
REQ-006 The block SHALL have port s_axis_tvalid input 1: input byte valid.
REQ-007 The block SHALL have port s_axis_tlast input 1: the byte is the last of its packet.
REQ-008 The block SHALL have port s_axis_tready output 1: the block accepts the input byte.
REQ-009 The block SHALL have port m_axis_tdata output 8: ASCII character out, feeding the UART transmitter.
REQ-010 The block SHALL have port m_axis_tvalid output 1: output character valid.
REQ-011 The block SHALL have port m_axis_tready input 1: downstream accepts the character; may be a one-cycle pulse asserted any number of cycles after m_axis_tvalid rises.

Function
REQ-012 A transfer SHALL occur on any rising edge where tvalid and tready are both 1, on either side.
REQ-013 FSM states SHALL be IDLE, HI, LO, SEP, CR, LF.
REQ-014 s_axis_tready SHALL be registered and SHALL be 1 only in IDLE while m_axis_tvalid is 0.
REQ-015 On an input transfer in IDLE, the block SHALL capture tdata and tlast, go to HI, and assert m_axis_tvalid with the high-nibble character on the next cycle (1-cycle latency).
REQ-016 Hex encoding: nibble 0-9 SHALL map to 0x30-0x39; nibble 10-15 SHALL map to 0x41-0x46 (UPPERCASE=1) or 0x61-0x66 (UPPERCASE=0).
REQ-017 m_axis_tdata and m_axis_tvalid SHALL be registered and SHALL stay stable from the rise of tvalid until the output transfer.
REQ-018 After the output transfer in HI, the FSM SHALL go to LO (low-nibble character).
REQ-019 After the output transfer in LO:
- if the captured tlast=1, or column==BYTES_PER_LINE-1, go to CR;
- otherwise go to SEP (0x20).
REQ-020 After the output transfer in SEP, the FSM SHALL go to IDLE; column SHALL increment.
REQ-021 After the output transfer in CR (0x0D), the FSM SHALL go to LF (0x0A).
REQ-022 After the output transfer in LF, the FSM SHALL go to IDLE and clear column to 0.
REQ-023 Each following character SHALL be presented on the cycle after the previous transfer; m_axis_tvalid SHALL fall on the cycle after the last character of a byte transfers.
REQ-024 column SHALL be 8 bits wide and SHALL never exceed BYTES_PER_LINE-1; with BYTES_PER_LINE=1, every byte SHALL end with CR LF.
REQ-025 Output order SHALL be strictly in input order; no byte or character SHALL be dropped or duplicated while reset is low.
REQ-026 Holding m_axis_tready at 0 SHALL stall the block indefinitely, with no state or data change.
REQ-027 When m_axis_tready is held at 1, the block SHALL sustain 1 character per cycle within a byte's sequence, plus 1 IDLE cycle per byte.

Reset
REQ-028 While reset=1, the block SHALL hold: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0x00, state=IDLE, column=0, captured byte=0, captured last=0.
REQ-029 Reset asserted mid-sequence SHALL abandon the current byte; no partial characters SHALL be emitted afterwards.
REQ-030 s_axis_tready SHALL rise on the first cycle after reset deasserts.

Structure
REQ-031 A shared package axis_hex_pkg SHALL hold the FSM state encoding and the ASCII constants (SP, CR, LF, '0', 'A', 'a').
REQ-032 One sub-module SHALL be used: hex_nibble_to_ascii (combinational, 4-bit in, UPPERCASE parameter, 8-bit out), instantiated once and muxed by high/low nibble.
REQ-033 The block SHALL contain no FIFO; buffering, if needed, is external.

Verification
REQ-034 Bytes 0x3A, 0xF0 with tlast on 0xF0, m_axis_tready held at 1 -> output "3A F0\r\n" = 0x33 0x41 0x20 0x46 0x30 0x0D 0x0A.
REQ-035 UPPERCASE=0, single byte 0xBC with tlast=1 -> output 0x62 0x63 0x0D 0x0A.
REQ-036 BYTES_PER_LINE=4, 6 bytes 0x00-0x05 with tlast only on 0x05 -> "00 01 02 03\r\n04 05\r\n"; column=0 at the end.
REQ-037 m_axis_tready driven as a 1-cycle pulse every 1085 cycles (UART model) -> m_axis_tdata stable between pulses; s_axis_tready low until the LF or SP transfer; no loss.
REQ-038 Reset asserted while in LO after byte 0x12 -> m_axis_tvalid=0 the next cycle; after release, byte 0x34 with tlast -> exactly "34\r\n", column 0.
REQ-039 Random s_axis_tvalid and m_axis_tready with 1000 bytes -> the scoreboard's decoded hex stream SHALL equal the input stream, with line lengths no greater than BYTES_PER_LINE.

Source files
------------

// File: rtl/axis_hex_pkg.sv
// Shared definitions for the AXI-Stream hex formatter: FSM state encoding
// and the ASCII characters the formatter emits.
package axis_hex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_SEP  = 3'd3,
    ST_CR   = 3'd4,
    ST_LF   = 3'd5
  } state_e;

  localparam logic [7:0] ASCII_SP      = 8'h20;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational map of one 4-bit nibble to its ASCII hex digit.
module hex_nibble_to_ascii
  import axis_hex_pkg::*;
#(
  parameter int unsigned UPPERCASE = 1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_ZERO;
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'd0, nibble};
    end else if (UPPERCASE != 0) begin
      ascii = ASCII_UPPER_A + {4'd0, nibble} - 8'd10;
    end else begin
      ascii = ASCII_LOWER_A + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/axis_hex_formatter.sv
// Turns a byte stream into hex text lines: "HH HH ... HH\r\n", breaking the
// line on tlast or after BYTES_PER_LINE bytes. One byte in flight, no FIFO.
module axis_hex_formatter
  import axis_hex_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE = 16,
  parameter int unsigned UPPERCASE      = 1
) (
  input  logic       clk125,
  input  logic       reset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready
);

  localparam logic [7:0] LAST_COL = 8'(BYTES_PER_LINE - 1);

  state_e     state_q, state_d;
  logic [7:0] column_q, column_d;
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic       s_ready_q, s_ready_d;
  logic       m_valid_q, m_valid_d;
  logic [7:0] m_data_q, m_data_d;

  logic       in_fire;
  logic       out_fire;
  logic [3:0] nibble_s;
  logic [7:0] nibble_char;

  assign in_fire  = s_axis_tvalid & s_ready_q;
  assign out_fire = m_valid_q & m_axis_tready;

  // In IDLE the high nibble comes straight off the input bus so it can be
  // registered on the capture edge; afterwards only the low nibble is needed.
  assign nibble_s = (state_q == ST_IDLE) ? s_axis_tdata[7:4] : byte_q[3:0];

  hex_nibble_to_ascii #(
    .UPPERCASE(UPPERCASE)
  ) u_nibble (
    .nibble(nibble_s),
    .ascii (nibble_char)
  );

  always_comb begin
    state_d   = state_q;
    column_d  = column_q;
    byte_d    = byte_q;
    last_d    = last_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          byte_d    = s_axis_tdata;
          last_d    = s_axis_tlast;
          state_d   = ST_HI;
          m_valid_d = 1'b1;
          m_data_d  = nibble_char;
        end else begin
          m_valid_d = 1'b0;
        end
      end
      ST_HI: begin
        if (out_fire) begin
          state_d  = ST_LO;
          m_data_d = nibble_char;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_LO: begin
        if (out_fire) begin
          if (last_q || (column_q == LAST_COL)) begin
            state_d  = ST_CR;
            m_data_d = ASCII_CR;
          end else begin
            state_d  = ST_SEP;
            m_data_d = ASCII_SP;
          end
        end else begin
          state_d = ST_LO;
        end
      end
      ST_SEP: begin
        if (out_fire) begin
          state_d   = ST_IDLE;
          m_valid_d = 1'b0;
          column_d  = column_q + 8'd1;
        end else begin
          state_d = ST_SEP;
        end
      end
      ST_CR: begin
        if (out_fire) begin
          state_d  = ST_LF;
          m_data_d = ASCII_LF;
        end else begin
          state_d = ST_CR;
        end
      end
      ST_LF: begin
        if (out_fire) begin
          state_d   = ST_IDLE;
          m_valid_d = 1'b0;
          column_d  = 8'd0;
        end else begin
          state_d = ST_LF;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        m_valid_d = 1'b0;
        column_d  = 8'd0;
      end
    endcase
    // Ready is offered only once the byte's last character has left.
    s_ready_d = (state_d == ST_IDLE) && !m_valid_d;
  end

  always_ff @(posedge clk125) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      column_q  <= 8'd0;
      byte_q    <= 8'd0;
      last_q    <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      column_q  <= column_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;

endmodule

// File: tb/tb_axis_hex_formatter.sv
// Randomized and directed bench for axis_hex_formatter against a text-level
// reference model (hex strings, line breaks by byte count).
module tb_axis_hex_formatter;

  localparam int BPL = 4;

  logic       clk125 = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tready = 1'b0;

  logic [7:0] s2_tdata = 8'h00;
  logic       s2_tvalid = 1'b0, s2_tlast = 1'b0, s2_tready;
  logic [7:0] m2_tdata;
  logic       m2_tvalid, m2_tready = 1'b0;

  axis_hex_formatter #(.BYTES_PER_LINE(BPL), .UPPERCASE(1)) dut (
    .clk125(clk125), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
  );

  axis_hex_formatter #(.BYTES_PER_LINE(1), .UPPERCASE(0)) dut_lc (
    .clk125(clk125), .reset(reset),
    .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tlast(s2_tlast),
    .s_axis_tready(s2_tready),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready)
  );

  always #4 clk125 = ~clk125;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] in_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rand_bytes[$];
  logic [8:0] in2_q[$];
  logic [7:0] got2_q[$];
  logic [7:0] exp2[12] = '{8'h62, 8'h63, 8'h0D, 8'h0A, 8'h64, 8'h65, 8'h0D, 8'h0A,
                           8'h39, 8'h61, 8'h0D, 8'h0A};
  int mcol = 0;
  int cyc = 0;
  int first_in, last_out;
  bit prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits.getc(int'(n));
  endfunction

  function automatic int hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    else if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    else return -1;
  endfunction

  // Reference: two hex digits, then CR LF at end of packet or full line, else a space.
  task automatic send(input logic [7:0] b, input bit last);
    in_q.push_back({last, b});
    exp_q.push_back(hex_char(b[7:4]));
    exp_q.push_back(hex_char(b[3:0]));
    if (last || mcol == BPL - 1) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      mcol = 0;
    end else begin
      exp_q.push_back(8'h20);
      mcol++;
    end
  endtask

  task automatic step(input bit in_ok, input bit out_ok);
    @(negedge clk125);
    cyc++;
    if (prev_hold) begin
      check_eq("hold_valid", 32'(m_tvalid), 32'd1);
      check_eq("hold_data", 32'(m_tdata), 32'(prev_data));
    end
    if (m_tvalid) check_eq("ready_while_busy", 32'(s_tready), 32'd0);
    s_tvalid = in_ok && (in_q.size() > 0);
    s_tdata  = s_tvalid ? in_q[0][7:0] : 8'h00;
    s_tlast  = s_tvalid ? in_q[0][8] : 1'b0;
    m_tready = out_ok;
    if (s_tvalid && s_tready) begin
      void'(in_q.pop_front());
      if (first_in < 0) first_in = cyc;
    end
    if (m_tvalid && m_tready) begin
      got_q.push_back(m_tdata);
      last_out = cyc;
    end
    prev_hold = m_tvalid && !m_tready;
    prev_data = m_tdata;
  endtask

  // mode 0: always ready/valid; 1: random; 2: UART-style one-cycle ready pulses.
  task automatic run(input int mode, input int budget, input string tag);
    int n;
    int bad;
    n = 0;
    first_in = -1;
    last_out = -1;
    while ((in_q.size() > 0 || got_q.size() < exp_q.size()) && n < budget) begin
      case (mode)
        0:       step(1'b1, 1'b1);
        1:       step($urandom_range(99) < 70, $urandom_range(99) < 50);
        default: step(1'b1, (cyc % 1085) == 0);
      endcase
      n++;
    end
    check_eq({tag, "_in_budget"}, 32'(n < budget), 32'd1);
    repeat (4) step(1'b0, 1'b1);
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    if (exp_q.size() <= 64) begin
      foreach (exp_q[i])
        check_eq($sformatf("%s_ch%0d", tag, i),
                 (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end else begin
      bad = 0;
      foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
      check_eq({tag, "_char_errors"}, 32'(bad), 32'd0);
    end
  endtask

  task automatic step2();
    @(negedge clk125);
    s2_tvalid = in2_q.size() > 0;
    s2_tdata  = s2_tvalid ? in2_q[0][7:0] : 8'h00;
    s2_tlast  = s2_tvalid ? in2_q[0][8] : 1'b0;
    m2_tready = 1'b1;
    if (s2_tvalid && s2_tready) void'(in2_q.pop_front());
    if (m2_tvalid) got2_q.push_back(m2_tdata);
  endtask

  initial begin
    int k;
    int nib_cnt, bidx, bad, linelen, maxline, d;
    logic [7:0] cur;

    // Reset values held while reset is high
    repeat (3) @(negedge clk125);
    check_eq("rst_s_tready", 32'(s_tready), 32'd0);
    check_eq("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("rst_m_tdata", 32'(m_tdata), 32'd0);
    reset = 1'b0;
    @(negedge clk125);
    check_eq("rst_ready_rise", 32'(s_tready), 32'd1);
    check_eq("rst_ready_rise_lc", 32'(s2_tready), 32'd1);

    send(8'h3A, 1'b0);
    send(8'hF0, 1'b1);
    run(0, 200, "basic");

    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) send(8'(i), i == 5);
    run(0, 200, "line4");
    check_eq("line4_cycles", 32'(last_out - first_in), 32'd25);

    got_q.delete(); exp_q.delete();
    send(8'hA5, 1'b0);
    send(8'h5A, 1'b0);
    send(8'h7E, 1'b1);
    run(2, 20000, "uart");

    // Reset in the middle of byte 0x12, while its low digit is offered
    got_q.delete(); exp_q.delete();
    in_q.push_back({1'b0, 8'h12});
    k = 0;
    while (got_q.size() < 1 && k < 20) begin
      step(1'b1, 1'b1);
      k++;
    end
    check_eq("mid_hi_char", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'h31);
    @(negedge clk125);
    check_eq("mid_lo_valid", 32'(m_tvalid), 32'd1);
    check_eq("mid_lo_char", 32'(m_tdata), 32'h32);
    reset = 1'b1;
    m_tready = 1'b0;
    s_tvalid = 1'b0;
    in_q.delete();
    @(negedge clk125);
    check_eq("mid_rst_valid", 32'(m_tvalid), 32'd0);
    check_eq("mid_rst_ready", 32'(s_tready), 32'd0);
    check_eq("mid_rst_data", 32'(m_tdata), 32'd0);
    reset = 1'b0;
    mcol = 0;
    prev_hold = 1'b0;
    got_q.delete();
    @(negedge clk125);
    check_eq("mid_ready_rise", 32'(s_tready), 32'd1);
    send(8'h34, 1'b1);
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b0);
    run(0, 200, "after_rst");

    // Lowercase, one byte per line
    in2_q.push_back({1'b1, 8'hBC});
    in2_q.push_back({1'b0, 8'hDE});
    in2_q.push_back({1'b1, 8'h9A});
    repeat (30) step2();
    check_eq("lc_len", 32'(got2_q.size()), 32'd12);
    foreach (exp2[i])
      check_eq($sformatf("lc_ch%0d", i),
               (i < got2_q.size()) ? 32'(got2_q[i]) : 32'hFFFF_FFFF, 32'(exp2[i]));

    // 1000 random bytes under random handshakes
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 1000; i++) begin
      cur = 8'($urandom);
      rand_bytes.push_back(cur);
      send(cur, $urandom_range(7) == 0);
    end
    run(1, 40000, "rand");

    nib_cnt = 0; bidx = 0; bad = 0; linelen = 0; maxline = 0; cur = 8'h00;
    foreach (got_q[i]) begin
      if (got_q[i] == 8'h0A) begin
        if (linelen > maxline) maxline = linelen;
        linelen = 0;
      end else if (got_q[i] != 8'h20 && got_q[i] != 8'h0D) begin
        d = hex_val(got_q[i]);
        if (d < 0) begin
          bad++;
        end else begin
          cur = {cur[3:0], 4'(d)};
          nib_cnt++;
          if (nib_cnt % 2 == 0) begin
            if (bidx >= rand_bytes.size() || rand_bytes[bidx] !== cur) bad++;
            bidx++;
            linelen++;
          end
        end
      end
    end
    check_eq("rand_decode_errors", 32'(bad), 32'd0);
    check_eq("rand_decode_count", 32'(bidx), 32'd1000);
    check_eq("rand_line_len_ok", 32'(maxline <= BPL), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
